// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display datapath.
// bin2bcd_seq honours the optional macro LEADING_ZERO_BLANK_EN.
package seg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned BCD_W     = 4;
  localparam logic [3:0]  BCD_BLANK = 4'hF;

  // 10^n, used to derive the largest value representable in n BCD digits.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more before the shift.
module bcd_add3
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] nib,
  output logic [BCD_W-1:0] adj
);

  always_comb begin
    adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock (shift-and-add-3).
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits in the committed result.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    overflow
);

  localparam int          BCD_TOT = BCD_W * DIGITS;
  localparam int          WORK_W  = BIN_W + BCD_TOT;
  localparam int          CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [63:0] MAX     = pow10(DIGITS) - 64'd1;

  state_t              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_adj, work_nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q;
  logic [BCD_TOT-1:0]  result, bcd_fmt;

  // Per-digit correction on the BCD half of the working register.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .nib (work_q[BIN_W+g*BCD_W +: BCD_W]),
        .adj (work_adj[BIN_W+g*BCD_W +: BCD_W])
      );
    end
  endgenerate

  assign work_adj[BIN_W-1:0] = work_q[BIN_W-1:0];
  assign work_nxt            = {work_adj[WORK_W-2:0], 1'b0};
  assign result              = work_nxt[WORK_W-1 -: BCD_TOT];

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
`endif

  always_comb begin
    bcd_fmt = result;
`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; the units digit is never blanked.
    lead = 1'b1;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      if (lead && (result[i*BCD_W +: BCD_W] == 4'h0)) begin
        bcd_fmt[i*BCD_W +: BCD_W] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
`endif
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == SHIFT);
  end

  // Datapath and committed result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd      <= {DIGITS{BCD_BLANK}};
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q <= {{BCD_TOT{1'b0}}, bin};
            cnt_q  <= CNT_W'(BIN_W - 1);
            ovf_q  <= (64'(bin) > MAX);
          end
        end
        SHIFT: begin
          work_q <= work_nxt;
          if (cnt_q == '0) begin
            done     <= 1'b1;
            overflow <= ovf_q;
            bcd      <= ovf_q ? {DIGITS{BCD_BLANK}} : bcd_fmt;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and model-based checks for bin2bcd_seq (BIN_W=14, DIGITS=4).
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic        busy, done, overflow;
  logic [15:0] bcd;

  int n_vec = 0;
  int n_err = 0;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Decimal reference via division, independent of the shift-add algorithm.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    logic [15:0] r;
    if (v > 9999) return 16'hFFFF;
    r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`ifdef LEADING_ZERO_BLANK_EN
    if (v < 10)        r[15:4]  = 12'hFFF;
    else if (v < 100)  r[15:8]  = 8'hFF;
    else if (v < 1000) r[15:12] = 4'hF;
`endif
    return r;
  endfunction

  // Called #1 after the accepting edge (lat0 edges already elapsed). Returns #1
  // after the edge following done.
  task automatic wait_done(input string tag, input int lat0,
                           input logic [15:0] eb, input logic eo);
    int lat  = lat0;
    int gaps = 0;
    while (!done && lat < 40) begin
      if (!busy) gaps++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},   lat, 14);
    chk({tag, "_busy"},  gaps, 0);
    chk({tag, "_bcd"},   bcd, eb);
    chk({tag, "_ovf"},   overflow, eo);
    chk({tag, "_idle"},  busy, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 1'b0);
    chk({tag, "_hold"},  {overflow, bcd}, {eo, eb});
  endtask

  task automatic run_conv(input string tag, input logic [13:0] b,
                          input logic [15:0] eb, input logic eo);
    @(negedge clk);
    bin   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(tag, 0, eb, eo);
  endtask

  initial begin
    int cnt;
    logic [13:0] r;

    // reset state
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf",  overflow, 1'b0);
    chk("rst_bcd",  bcd, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    run_conv("v1234", 14'd1234, 16'h1234, 1'b0);
    run_conv("v9999", 14'd9999, 16'h9999, 1'b0);
    run_conv("v10000", 14'd10000, 16'hFFFF, 1'b1);
    run_conv("v16383", 14'd16383, 16'hFFFF, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    run_conv("v0",   14'd0,   16'hFFF0, 1'b0);
    run_conv("v205", 14'd205, 16'hF205, 1'b0);
`else
    run_conv("v0",   14'd0,   16'h0000, 1'b0);
    run_conv("v205", 14'd205, 16'h0205, 1'b0);
`endif

    // start held high; bin changes mid-conversion; start in done cycle accepted
    @(negedge clk);
    bin   = 14'd77;
    start = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    bin = 14'd42;
`ifdef LEADING_ZERO_BLANK_EN
    wait_done("v77", 5, 16'hFF77, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    start = 1'b0;
    wait_done("v42", 0, 16'hFF42, 1'b0);
`else
    wait_done("v77", 5, 16'h0077, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    start = 1'b0;
    wait_done("v42", 0, 16'h0042, 1'b0);
`endif

    // async reset during shift 7
    @(negedge clk);
    bin   = 14'd1234;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_bcd",  bcd, 16'hFFFF);
    chk("arst_ovf",  overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    chk("arst_quiet", cnt, 0);
    run_conv("v5678", 14'd5678, 16'h5678, 1'b0);

    // random values against the reference model
    for (int i = 0; i < 1000; i++) begin
      r = 14'($urandom_range(0, 16383));
      run_conv("rnd", r, ref_bcd(r), r > 14'd9999);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
